// File: rtl/text_console.sv
// text_console
//   Character-stream front end for the text-mode display. Consumes ASCII
//   bytes over a valid/ready handshake, tracks the cursor, interprets
//   LF/CR/BS/FF and produces a one-cell-per-cycle write port into video
//   memory. Handles screen clear and per-line clear on wrap (rolling
//   display, no scrolling).
//
//   Ports:
//     CLK_CPU             in   sole clock, rising edge
//     reset               in   asynchronous, active-high
//     char_valid          in   char_data holds a byte to consume
//     char_data[7:0]      in   ASCII byte
//     char_ready          out  byte accepted this cycle if char_valid
//     video_write_enable  out  write strobe, one cell per cycle
//     video_write_data    out  byte to write
//     video_write_addr    out  cell address = row*COLS + col
//     cursor_row          out  current cursor row
//     cursor_col          out  current cursor column
module text_console #(
   parameter  int COLS   = 64,
   parameter  int ROWS   = 24,
   parameter  int ADDR_W = 11,
   localparam int ROW_W  = $clog2(ROWS),
   localparam int COL_W  = $clog2(COLS)
) (
   input  logic              CLK_CPU,
   input  logic              reset,
   input  logic              char_valid,
   input  logic [7:0]        char_data,
   output logic              char_ready,
   output logic              video_write_enable,
   output logic [7:0]        video_write_data,
   output logic [ADDR_W-1:0] video_write_addr,
   output logic [ROW_W-1:0]  cursor_row,
   output logic [COL_W-1:0]  cursor_col
);

   localparam int CELLS = COLS * ROWS;

   typedef enum logic [1:0] {
      CLEAR_ALL  = 2'd0,
      CLEAR_LINE = 2'd1,
      IDLE       = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   cnt_q, cnt_d;
   logic                we_q, we_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [7:0]          data_q, data_d;
   logic [ROW_W-1:0]    row_q, row_d;
   logic [COL_W-1:0]    col_q, col_d;
   logic                ready_q, ready_d;

   logic [ADDR_W-1:0]   row_base;
   logic [ADDR_W-1:0]   cur_addr;
   logic [ADDR_W-1:0]   clr_last;
   logic [ROW_W-1:0]    next_row;

   assign row_base = ADDR_W'(row_q) * ADDR_W'(COLS);
   assign cur_addr = row_base + ADDR_W'(col_q);
   assign clr_last = (state_q == CLEAR_ALL) ? ADDR_W'(CELLS - 1) : ADDR_W'(COLS - 1);
   // Rolling display: moving past the last row wraps to row 0.
   assign next_row = (row_q == ROW_W'(ROWS - 1)) ? '0 : row_q + ROW_W'(1);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      we_d    = 1'b0;
      addr_d  = addr_q;
      data_d  = data_q;
      row_d   = row_q;
      col_d   = col_q;

      case (state_q)
         CLEAR_ALL, CLEAR_LINE: begin
            we_d   = 1'b1;
            addr_d = ((state_q == CLEAR_ALL) ? '0 : row_base) + cnt_q;
            data_d = 8'h20;
            if (state_q == CLEAR_ALL) begin
               row_d = '0;
               col_d = '0;
            end
            // The edge presenting the last cell also returns to IDLE so
            // char_ready rises alongside the final clear write.
            if (cnt_q == clr_last) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + ADDR_W'(1);
            end
         end
         default: begin
            if (char_valid && ready_q) begin
               if (char_data >= 8'h20 && char_data <= 8'h7E) begin
                  we_d   = 1'b1;
                  addr_d = cur_addr;
                  data_d = char_data;
                  if (col_q == COL_W'(COLS - 1)) begin
                     col_d   = '0;
                     row_d   = next_row;
                     state_d = CLEAR_LINE;
                     cnt_d   = '0;
                  end else begin
                     col_d = col_q + COL_W'(1);
                  end
               end else begin
                  case (char_data)
                     8'h0A: begin
                        col_d   = '0;
                        row_d   = next_row;
                        state_d = CLEAR_LINE;
                        cnt_d   = '0;
                     end
                     8'h0D: col_d = '0;
                     8'h08: begin
                        if (col_q != '0) begin
                           col_d  = col_q - COL_W'(1);
                           we_d   = 1'b1;
                           addr_d = cur_addr - ADDR_W'(1);
                           data_d = 8'h20;
                        end
                     end
                     8'h0C: begin
                        state_d = CLEAR_ALL;
                        cnt_d   = '0;
                        row_d   = '0;
                        col_d   = '0;
                     end
                     default: ;
                  endcase
               end
            end
         end
      endcase

      ready_d = (state_d == IDLE);
   end

   always_ff @(posedge CLK_CPU or posedge reset) begin
      if (reset) begin
         state_q <= CLEAR_ALL;
         cnt_q   <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         data_q  <= 8'h20;
         row_q   <= '0;
         col_q   <= '0;
         ready_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         row_q   <= row_d;
         col_q   <= col_d;
         ready_q <= ready_d;
      end
   end

   assign char_ready         = ready_q;
   assign video_write_enable = we_q;
   assign video_write_data   = data_q;
   assign video_write_addr   = addr_q;
   assign cursor_row         = row_q;
   assign cursor_col         = col_q;

endmodule
